// File: rtl/burst_arbiter_if.sv
// burst_arbiter_if: one Avalon-MM burst port; master drives command and write data, slave returns read data and stall
interface burst_arbiter_if #(
  parameter int WIDTHA = 10,
  parameter int WIDTHD = 16
);
  localparam int WIDTHB = 8;
  logic [WIDTHA-1:0] address;
  logic [WIDTHD-1:0] writedata;
  logic [WIDTHB-1:0] burstcount;
  logic read;
  logic write;
  logic [WIDTHD-1:0] readdata;
  logic readdatavalid;
  logic waitrequest;
  modport master (
    output address, writedata, burstcount, read, write,
    input  readdata, readdatavalid, waitrequest
  );
  modport slave (
    input  address, writedata, burstcount, read, write,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/burst_arbiter.sv
// burst_arbiter: burst-granular round-robin arbiter sharing one Avalon-MM burst RAM port between two masters
module burst_arbiter #(
  parameter int WIDTHA = 10,
  parameter int WIDTHD = 16
) (
  input  logic            clock,
  input  logic            clock_areset_n,
  burst_arbiter_if.slave  s0,
  burst_arbiter_if.slave  s1,
  burst_arbiter_if.master m,
  output logic [1:0]      grant,
  output logic            busy
);
  localparam int WIDTHB = 8;
  localparam logic [1:0] IDLE = 2'd0, RD_CMD = 2'd1, RD_DATA = 2'd2, WR_DATA = 2'd3;
  logic [1:0]        state;
  logic [WIDTHB-1:0] count;
  logic              last;
  logic              req0, req1, any_req, sel, sel_read, zero_burst, beat, g_write;
  logic [WIDTHB-1:0] sel_burstcount, g_burstcount;
  logic [WIDTHA-1:0] g_address;
  logic [WIDTHD-1:0] g_writedata;

  assign req0           = s0.read | s0.write;
  assign req1           = s1.read | s1.write;
  assign any_req        = req0 | req1;
  // on a tie the port that did not go last wins; otherwise the lone requester
  assign sel            = (req0 & req1) ? ~last : req1;
  assign sel_read       = sel ? s1.read : s0.read;
  assign sel_burstcount = sel ? s1.burstcount : s0.burstcount;
  assign zero_burst     = (state == IDLE) & any_req & (sel_burstcount == '0);

  assign g_address      = grant[1] ? s1.address : s0.address;
  assign g_writedata    = grant[1] ? s1.writedata : s0.writedata;
  assign g_burstcount   = grant[1] ? s1.burstcount : s0.burstcount;
  assign g_write        = grant[1] ? s1.write : s0.write;
  assign beat           = (state == RD_DATA) ? m.readdatavalid : ((state == WR_DATA) & g_write & ~m.waitrequest);

  assign m.address      = g_address;
  assign m.writedata    = g_writedata;
  assign m.burstcount   = g_burstcount;
  assign m.read         = (state == RD_CMD);
  assign m.write        = (state == WR_DATA) & g_write;

  // in IDLE only a zero-length request is acknowledged; later the owner sees the RAM stall
  assign s0.waitrequest   = (state == IDLE) ? ~(zero_burst & ~sel) : (~grant[0] | (state == RD_DATA) | m.waitrequest);
  assign s1.waitrequest   = (state == IDLE) ? ~(zero_burst & sel) : (~grant[1] | (state == RD_DATA) | m.waitrequest);
  assign s0.readdatavalid = (state == RD_DATA) & grant[0] & m.readdatavalid;
  assign s1.readdatavalid = (state == RD_DATA) & grant[1] & m.readdatavalid;
  assign s0.readdata      = m.readdata;
  assign s1.readdata      = m.readdata;
  assign busy             = (state != IDLE);

  // arbitrate in IDLE, then hold the grant until the last beat of the burst
  always_ff @(posedge clock or negedge clock_areset_n)
    if (!clock_areset_n) begin
      state <= IDLE;
      grant <= '0;
      count <= '0;
      last  <= 1'b1;
    end else if (state == IDLE) begin
      if (any_req) begin
        last <= sel;
        if (!zero_burst) begin
          grant <= sel ? 2'b10 : 2'b01;
          count <= sel_burstcount;
          state <= sel_read ? RD_CMD : WR_DATA;
        end
      end
    end else if (state == RD_CMD) begin
      if (!m.waitrequest) state <= RD_DATA;
    end else if (beat) begin
      count <= count - 1'b1;
      if (count == WIDTHB'(1)) begin
        state <= IDLE;
        grant <= '0;
      end
    end
endmodule

// File: doc/burst_arbiter.md
# burst_arbiter

Two-port, burst-granular round-robin arbiter that shares one Avalon-MM burst RAM port between two burst masters, e.g. the convolution read master and the result write-back master. A grant is held for a whole burst: all write beats accepted, or all read beats returned. The other port stalls on waitrequest until the burst completes. The block sits between the masters and the on-chip RAM inside the convolution_burst component.

## Interface
- WIDTHA, 10: address width, shared by both slave ports and the master port.
- WIDTHD, 16: data width.
- WIDTHB, 8: burstcount width (localparam, fixed).

- clock  in  1  sole clock; all logic on the rising edge.
- clock_areset_n  in  1  reset, asynchronous, active-low.
- s0_/s1_address  in  WIDTHA  burst base address; held stable for the whole burst.
- s0_/s1_writedata  in  WIDTHD  write beat data.
- s0_/s1_burstcount  in  WIDTHB  beats in the burst; held with read/write.
- s0_/s1_read, s0_/s1_write  in  1  burst request.
- s0_/s1_readdata  out  WIDTHD  equals m_readdata, broadcast to both ports.
- s0_/s1_readdatavalid  out  1  read beat, granted port only.
- s0_/s1_waitrequest  out  1  stall.
- m_address, m_writedata, m_burstcount  out  muxed from the granted port.
- m_read, m_write  out  1  granted port's request, gated by state.
- m_readdata  in  WIDTHD;  m_readdatavalid, m_waitrequest  in  1.
- grant  out  2  one-hot owner of the RAM (00 when idle).
- busy  out  1  state != IDLE.

## Operation
- Registers: state, grant, count (WIDTHB), last (round-robin pointer).
- States:
  - IDLE: no RAM access.
  - RD_CMD: read command presented to the RAM.
  - RD_DATA: waiting for read beats.
  - WR_DATA: write beats in flight.
- IDLE, arbitration:
  - req[i] = si_read | si_write.
  - If both ports request, grant goes to the port ≠ last.
  - If one port requests, it is granted.
  - On a grant: load count = burstcount; last = granted port.
  - Next state: RD_CMD if read, WR_DATA if write. If a port asserts read and write together, read wins.
- Zero burstcount: the request is consumed in a single cycle with no RAM traffic. That port's waitrequest is low for 1 cycle in IDLE and the pointer still advances. No readdatavalid is produced.
- RD_CMD:
  - m_read = 1; granted waitrequest = m_waitrequest.
  - On ~m_waitrequest, go to RD_DATA.
- RD_DATA:
  - m_read = 0; granted waitrequest = 1.
  - Each m_readdatavalid is forwarded to the granted port's readdatavalid and decrements count.
  - Beat with count==1: go to IDLE, grant = 00.
- WR_DATA:
  - m_write = granted port's write; granted waitrequest = m_waitrequest.
  - Each accepted beat (write & ~m_waitrequest) decrements count.
  - Accepted beat with count==1: go to IDLE.
- The non-granted port's waitrequest is always 1. Its request stays pending and is served next (fairness ≤ 1 burst of wait).
- Stray m_readdatavalid outside RD_DATA (e.g. after a reset mid-burst) is dropped and never forwarded.
- count only decrements, never wraps. Maximum burst is 2^WIDTHB−1 beats.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, grant = 00, count = 0, last = 1 (port 0 wins the first tie).
  - Both waitrequests = 1; readdatavalids, m_read, m_write, busy = 0.
- Reset mid-burst aborts immediately: no further beats are forwarded. The RAM's residual beats are dropped per the stray rule.
- Arbitration costs 1 cycle: a request seen in IDLE at cycle t is presented on m_* at t+1.
- Between bursts there is 1 idle cycle in IDLE (no back-to-back grant).
- The m_* mux and the slave waitrequest/readdatavalid paths are combinational from registered state and grant. Added read latency is 0.
- A request and the completion of the previous burst in the same cycle: the new request is evaluated in the following IDLE cycle.

## Test plan
- Reset: hold clock_areset_n low 3 cycles → both waitrequests = 1, grant = 00, m_read = m_write = 0. Release → first request granted 1 cycle later.
- Single read: s0 read, address 0x010, burstcount 4 → one m_read accepted, then exactly 4 s0_readdatavalid carrying ram[0x010..0x013], s1_readdatavalid = 0, then back to IDLE with grant = 00.
- Contention: s0 read burst 8 and s1 write burst 3 asserted together after reset → s0 served first. s1 waitrequest stays 1 until s0's 8th beat. Next, s1's 3 beats land at s1_address+0..2. Repeat with both requesting → s0 served next (alternation).
- Back-pressure: m_waitrequest high for 2 cycles on write beats 1 and 3 of a 4-beat burst → exactly 4 beats accepted, with no duplicate or skipped data.
- Zero burstcount: s1 read with burstcount 0 → s1_waitrequest low for 1 cycle, no m_read, no readdatavalid, last = 1.
- Abort: assert reset after 2 of 6 read beats → outputs return to reset values asynchronously. Later stray m_readdatavalid is not forwarded. A new s1 burst completes normally.
